// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared constants and FSM state type for run_ctrl.
// Holds default address/counter widths and the launch FSM encoding.
package run_ctrl_pkg;

    localparam int ADDR_W  = 9;
    localparam int CNT_W   = 16;
    localparam int START_W = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/run_ctrl_if.sv
// run_ctrl_if: host/core-side signal bundle of run_ctrl.
// master = host+core side driving go/abort/ack/cpu_done; slave = run_ctrl.
interface run_ctrl_if #(
    parameter int ADDR_W = run_ctrl_pkg::ADDR_W,
    parameter int CNT_W  = run_ctrl_pkg::CNT_W
);

    logic              go;
    logic [ADDR_W-1:0] prog_addr;
    logic              abort;
    logic              ack;
    logic              cpu_done;
    logic              cpu_start;
    logic [ADDR_W-1:0] cpu_start_addr;
    logic              busy;
    logic              finished;
    logic              timeout;
    logic [CNT_W-1:0]  cycle_count;

    modport master (
        output go, prog_addr, abort, ack, cpu_done,
        input  cpu_start, cpu_start_addr, busy,
        input  finished, timeout, cycle_count
    );

    modport slave (
        input  go, prog_addr, abort, ack, cpu_done,
        output cpu_start, cpu_start_addr, busy,
        output finished, timeout, cycle_count
    );

endinterface

// File: rtl/run_ctrl_sat_counter.sv
// sat_counter: W-bit up counter with synchronous clear and enable.
// Ports: clk, rst_n (sync, active-low), clr, en -> count (sticks at all-ones).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: launches a core at a latched address, times the run, reports done.
// Ports: clk, rst_n (sync, active-low), bus (run_ctrl_if.slave).
// Optional watchdog: define RUN_CTRL_WATCHDOG_EN to end runs at WDOG_LIMIT.
module run_ctrl #(
    parameter int          ADDR_W       = run_ctrl_pkg::ADDR_W,
    parameter int          CNT_W        = run_ctrl_pkg::CNT_W,
    parameter int          START_CYCLES = 2,
    parameter int unsigned WDOG_LIMIT   = 32'h0000_FFFF
) (
    input  logic       clk,
    input  logic       rst_n,
    run_ctrl_if.slave  bus
);

    import run_ctrl_pkg::*;

    localparam logic [1:0] IDLE  = S_IDLE;
    localparam logic [1:0] START = S_START;
    localparam logic [1:0] RUN   = S_RUN;
    localparam logic [1:0] DONE  = S_DONE;

    localparam logic [START_W-1:0] START_LOAD = START_W'(START_CYCLES - 1);

    logic [1:0]         state_q, state_d;
    logic [START_W-1:0] scnt_q, scnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               to_q, to_d;
    logic               cnt_clr;
    logic               cnt_en;
    logic [CNT_W-1:0]   cnt;
    logic               wdog_hit;
    logic               accept;

`ifdef RUN_CTRL_WATCHDOG_EN
    assign wdog_hit = (cnt == CNT_W'(WDOG_LIMIT));
`else
    assign wdog_hit = 1'b0;
`endif

    // go is only honoured while the core is not owned by a launch/run
    assign accept = bus.go && ((state_q == IDLE) || (state_q == DONE));

    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        addr_d  = addr_q;
        to_d    = to_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        if (accept) begin
            state_d = START;
            addr_d  = bus.prog_addr;
            scnt_d  = START_LOAD;
            to_d    = 1'b0;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                START: begin
                    // cpu_done is stale from the previous program here
                    if (bus.abort) begin
                        state_d = IDLE;
                    end else if (scnt_q == '0) begin
                        state_d = RUN;
                    end else begin
                        scnt_d = scnt_q - 1'b1;
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        state_d = IDLE;
                    end else if (bus.cpu_done) begin
                        state_d = DONE;
                    end else if (wdog_hit) begin
                        state_d = DONE;
                        to_d    = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                DONE: begin
                    if (bus.ack) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            scnt_q  <= '0;
            addr_q  <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            addr_q  <= addr_d;
            to_q    <= to_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (cnt)
    );

    assign bus.cpu_start      = (state_q == START);
    assign bus.busy           = (state_q == START) || (state_q == RUN);
    assign bus.finished       = (state_q == DONE);
    assign bus.timeout        = to_q && (state_q == DONE);
    assign bus.cpu_start_addr = addr_q;
    assign bus.cycle_count    = cnt;

endmodule
